// File: rtl/iexec_imem.sv
// iexec_imem: EX/MEM pipeline latch that issues the data-memory request,
// stalls upstream while the access is outstanding and freezes on halt.
module iexec_imem (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic        dhit,
    input  logic [31:0] dmemload,
    input  logic [31:0] aluout_in,
    input  logic [31:0] rdat2_in,
    input  logic [31:0] pcplusfour_in,
    input  logic [31:0] luiout_in,
    input  logic [4:0]  wsel_in,
    input  logic        RegWr_in,
    input  logic        MemtoReg_in,
    input  logic        dREN_in,
    input  logic        dWEN_in,
    input  logic        jal_s_in,
    input  logic        lui_in,
    input  logic        halt_in,
    output logic        dmemREN,
    output logic        dmemWEN,
    output logic [31:0] dmemaddr,
    output logic [31:0] dmemstore,
    output logic        stall_for_data,
    output logic [31:0] aluout_out,
    output logic [31:0] load_out,
    output logic [31:0] pcplusfour_out,
    output logic [31:0] luiout_out,
    output logic [4:0]  wsel_out,
    output logic        RegWr_out,
    output logic        MemtoReg_out,
    output logic        jal_s_out,
    output logic        lui_out,
    output logic        valid_out,
    output logic        halt_out
);
    typedef enum logic [1:0] {IDLE, MEM, HALT} state_t;
    state_t      r_state;
    logic [31:0] r_alu, r_rdat2, r_pc4, r_lui, r_load;
    logic [4:0]  r_wsel;
    logic        r_regwr, r_m2r, r_dren, r_dwen, r_jal, r_luis, r_halt;
    logic        w_done, w_en;
    assign w_done = (r_state == MEM) & dhit;
    assign stall_for_data = (r_state == MEM) & !dhit;
    // A halt that rode in with a memory op must not be overwritten by the next instruction.
    assign w_en = ihit & !stall_for_data & (r_state != HALT) & !(w_done & r_halt);
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= IDLE;
            r_alu   <= '0;
            r_rdat2 <= '0;
            r_pc4   <= '0;
            r_lui   <= '0;
            r_load  <= '0;
            r_wsel  <= '0;
            r_regwr <= 1'b0;
            r_m2r   <= 1'b0;
            r_dren  <= 1'b0;
            r_dwen  <= 1'b0;
            r_jal   <= 1'b0;
            r_luis  <= 1'b0;
            r_halt  <= 1'b0;
        end else begin
            if (w_done & r_dren)
                r_load <= dmemload;
            if (w_en) begin
                r_alu   <= aluout_in;
                r_rdat2 <= rdat2_in;
                r_pc4   <= pcplusfour_in;
                r_lui   <= luiout_in;
                r_wsel  <= wsel_in;
                r_regwr <= RegWr_in;
                r_m2r   <= MemtoReg_in;
                r_dren  <= dREN_in;
                r_dwen  <= dWEN_in;
                r_jal   <= jal_s_in;
                r_luis  <= lui_in;
                r_halt  <= halt_in;
                r_state <= (dREN_in | dWEN_in) ? MEM : halt_in ? HALT : IDLE;
            end else if (w_done) begin
                r_state <= r_halt ? HALT : IDLE;
            end
        end
    end
    assign valid_out      = (r_state != MEM);
    assign halt_out       = (r_state == HALT);
    assign dmemREN        = (r_state == MEM) & r_dren;
    assign dmemWEN        = (r_state == MEM) & r_dwen;
    assign dmemaddr       = r_alu;
    assign dmemstore      = r_rdat2;
    assign aluout_out     = r_alu;
    assign load_out       = r_load;
    assign pcplusfour_out = r_pc4;
    assign luiout_out     = r_lui;
    assign wsel_out       = r_wsel;
    assign RegWr_out      = r_regwr & valid_out;
    assign MemtoReg_out   = r_m2r;
    assign jal_s_out      = r_jal;
    assign lui_out        = r_luis;
endmodule

// File: tb/tb_iexec_imem.sv
// tb_iexec_imem: directed scenarios plus randomized traffic against a
// transaction-level model of the EX/MEM latch.
module tb_iexec_imem;
    logic        CLK = 1'b0, nRST = 1'b0, ihit, dhit;
    logic [31:0] dmemload, aluout_in, rdat2_in, pcplusfour_in, luiout_in;
    logic [4:0]  wsel_in;
    logic        RegWr_in, MemtoReg_in, dREN_in, dWEN_in, jal_s_in, lui_in, halt_in;
    logic        dmemREN, dmemWEN, stall_for_data, RegWr_out, MemtoReg_out, jal_s_out, lui_out, valid_out, halt_out;
    logic [31:0] dmemaddr, dmemstore, aluout_out, load_out, pcplusfour_out, luiout_out;
    logic [4:0]  wsel_out;
    int n_cmp = 0, n_err = 0;

    iexec_imem dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .dmemload(dmemload),
        .aluout_in(aluout_in), .rdat2_in(rdat2_in), .pcplusfour_in(pcplusfour_in), .luiout_in(luiout_in),
        .wsel_in(wsel_in), .RegWr_in(RegWr_in), .MemtoReg_in(MemtoReg_in), .dREN_in(dREN_in),
        .dWEN_in(dWEN_in), .jal_s_in(jal_s_in), .lui_in(lui_in), .halt_in(halt_in),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .stall_for_data(stall_for_data), .aluout_out(aluout_out), .load_out(load_out),
        .pcplusfour_out(pcplusfour_out), .luiout_out(luiout_out), .wsel_out(wsel_out),
        .RegWr_out(RegWr_out), .MemtoReg_out(MemtoReg_out), .jal_s_out(jal_s_out),
        .lui_out(lui_out), .valid_out(valid_out), .halt_out(halt_out)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_in();
        {ihit, dhit, RegWr_in, MemtoReg_in, dREN_in, dWEN_in, jal_s_in, lui_in, halt_in} = '0;
        {dmemload, aluout_in, rdat2_in, pcplusfour_in, luiout_in} = '0;
        wsel_in = '0;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        #2;
        nRST = 1'b1;
    endtask

    task automatic test_reset();
        clear_in();
        tick();
        nRST = 1'b1;
        ihit = 1; dREN_in = 1; RegWr_in = 1; aluout_in = 32'h44; wsel_in = 9; pcplusfour_in = 32'h1004;
        tick();
        clear_in();
        #1;
        n_cmp++;
        if (dmemREN !== 1'b1) begin n_err++; $display("FAIL reset_pre_req got %b want 1", dmemREN); end
        nRST = 1'b0;
        #1;
        n_cmp++;
        if ({dmemREN, dmemWEN, stall_for_data, valid_out, halt_out, RegWr_out, MemtoReg_out, jal_s_out, lui_out} !== 9'b000100000) begin
            n_err++;
            $display("FAIL reset_ctrl got %b want 000100000", {dmemREN, dmemWEN, stall_for_data, valid_out, halt_out, RegWr_out, MemtoReg_out, jal_s_out, lui_out});
        end
        n_cmp++;
        if ({dmemaddr, dmemstore, aluout_out, load_out, pcplusfour_out, luiout_out, wsel_out} !== '0) begin
            n_err++;
            $display("FAIL reset_data got %h want 0", {dmemaddr, dmemstore, aluout_out, load_out, pcplusfour_out, luiout_out, wsel_out});
        end
        nRST = 1'b1;
    endtask

    task automatic test_alu();
        clear_in();
        ihit = 1; aluout_in = 32'h1234; wsel_in = 5; RegWr_in = 1;
        tick();
        clear_in();
        #1;
        n_cmp++;
        if ({aluout_out, wsel_out, RegWr_out} !== {32'h1234, 5'd5, 1'b1}) begin
            n_err++; $display("FAIL alu_pass got %h/%0d/%b want 1234/5/1", aluout_out, wsel_out, RegWr_out);
        end
        n_cmp++;
        if ({dmemREN, dmemWEN, stall_for_data, valid_out} !== 4'b0001) begin
            n_err++; $display("FAIL alu_noreq got %b want 0001", {dmemREN, dmemWEN, stall_for_data, valid_out});
        end
    endtask

    // Load stalls for three cycles, then dhit arrives without ihit.
    task automatic test_load();
        clear_in();
        ihit = 1; dREN_in = 1; aluout_in = 32'h80; RegWr_in = 1; MemtoReg_in = 1; wsel_in = 3;
        tick();
        clear_in();
        ihit = 1; aluout_in = 32'h999; dmemload = 32'hCAFEF00D;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if ({dmemREN, dmemaddr, stall_for_data, RegWr_out, valid_out} !== {1'b1, 32'h80, 1'b1, 1'b0, 1'b0}) begin
                n_err++; $display("FAIL load_wait%0d got %b/%h/%b/%b/%b want 1/80/1/0/0", i, dmemREN, dmemaddr, stall_for_data, RegWr_out, valid_out);
            end
            tick();
        end
        ihit = 0; dhit = 1;
        #1;
        n_cmp++;
        if ({dmemREN, stall_for_data} !== 2'b10) begin
            n_err++; $display("FAIL load_hit_cycle got %b want 10", {dmemREN, stall_for_data});
        end
        tick();
        dhit = 0;
        #1;
        n_cmp++;
        if ({load_out, RegWr_out, dmemREN, valid_out, aluout_out, wsel_out} !== {32'hCAFEF00D, 1'b1, 1'b0, 1'b1, 32'h80, 5'd3}) begin
            n_err++; $display("FAIL load_done got %h/%b/%b/%b/%h/%0d want cafef00d/1/0/1/80/3", load_out, RegWr_out, dmemREN, valid_out, aluout_out, wsel_out);
        end
    endtask

    task automatic test_dhit_no_ihit();
        clear_in();
        dhit = 1; dmemload = 32'h1111_2222; aluout_in = 32'h3;
        tick();
        tick();
        n_cmp++;
        if ({aluout_out, load_out, valid_out, dmemREN} !== {32'h80, 32'hCAFEF00D, 1'b1, 1'b0}) begin
            n_err++; $display("FAIL idle_hold got %h/%h/%b/%b want 80/cafef00d/1/0", aluout_out, load_out, valid_out, dmemREN);
        end
        dhit = 0; ihit = 1; aluout_in = 32'h55; wsel_in = 2;
        tick();
        clear_in();
        n_cmp++;
        if ({aluout_out, wsel_out} !== {32'h55, 5'd2}) begin
            n_err++; $display("FAIL idle_next got %h/%0d want 55/2", aluout_out, wsel_out);
        end
    endtask

    task automatic test_store();
        clear_in();
        ihit = 1; dWEN_in = 1; rdat2_in = 32'hDEAD; aluout_in = 32'h100;
        tick();
        clear_in();
        ihit = 1; dhit = 1; aluout_in = 32'h200; RegWr_in = 1; wsel_in = 7;
        #1;
        n_cmp++;
        if ({dmemWEN, dmemREN, dmemstore, dmemaddr, stall_for_data} !== {1'b1, 1'b0, 32'hDEAD, 32'h100, 1'b0}) begin
            n_err++; $display("FAIL store_req got %b/%b/%h/%h/%b want 1/0/dead/100/0", dmemWEN, dmemREN, dmemstore, dmemaddr, stall_for_data);
        end
        tick();
        clear_in();
        #1;
        n_cmp++;
        if ({dmemWEN, aluout_out, wsel_out, RegWr_out, valid_out} !== {1'b0, 32'h200, 5'd7, 1'b1, 1'b1}) begin
            n_err++; $display("FAIL store_next got %b/%h/%0d/%b/%b want 0/200/7/1/1", dmemWEN, aluout_out, wsel_out, RegWr_out, valid_out);
        end
    endtask

    task automatic test_halt();
        clear_in();
        ihit = 1; halt_in = 1; aluout_in = 32'h77; wsel_in = 4;
        tick();
        for (int i = 0; i < 6; i++) begin
            ihit = 1; dhit = 1'($urandom); aluout_in = $urandom; dREN_in = 1'($urandom); dWEN_in = 1'($urandom);
            wsel_in = 5'($urandom); halt_in = 0;
            #1;
            n_cmp++;
            if ({halt_out, aluout_out, wsel_out, dmemREN, dmemWEN, stall_for_data, valid_out} !== {1'b1, 32'h77, 5'd4, 4'b0001}) begin
                n_err++; $display("FAIL halt_frozen%0d got %b/%h/%0d/%b want 1/77/4/0001", i, halt_out, aluout_out, wsel_out, {dmemREN, dmemWEN, stall_for_data, valid_out});
            end
            tick();
        end
        clear_in();
        do_reset();
        n_cmp++;
        if ({halt_out, aluout_out} !== 33'd0) begin
            n_err++; $display("FAIL halt_reset got %b/%h want 0/0", halt_out, aluout_out);
        end
    endtask

    typedef struct packed {
        logic [31:0] alu, rdat2, pc4, lui;
        logic [4:0]  wsel;
        logic        regwr, m2r, dren, dwen, jal, luis, halt;
    } fld_t;

    task automatic test_random();
        fld_t f, nf;
        logic [31:0] m_load = '0;
        bit pend = 0, halted = 0, done, en;
        int hcnt = 0;
        logic [8:0]   exp_c;
        logic [196:0] exp_d;
        f = '0;
        clear_in();
        do_reset();
        tick();
        for (int i = 0; i < 3000; i++) begin
            if ((halted && hcnt > 4) || $urandom_range(0, 99) == 0) begin
                do_reset();
                f = '0; m_load = '0; pend = 0; halted = 0; hcnt = 0;
            end
            nf = fld_t'({$urandom, $urandom, $urandom, $urandom, 5'($urandom), 7'($urandom)});
            nf.dren = ($urandom_range(0, 3) == 0);
            nf.dwen = ($urandom_range(0, 6) == 0);
            nf.halt = ($urandom_range(0, 29) == 0);
            ihit = ($urandom_range(0, 3) != 0);
            dhit = ($urandom_range(0, 4) < 2);
            dmemload = $urandom;
            {aluout_in, rdat2_in, pcplusfour_in, luiout_in, wsel_in} = {nf.alu, nf.rdat2, nf.pc4, nf.lui, nf.wsel};
            {RegWr_in, MemtoReg_in, dREN_in, dWEN_in, jal_s_in, lui_in, halt_in} = {nf.regwr, nf.m2r, nf.dren, nf.dwen, nf.jal, nf.luis, nf.halt};
            #1;
            exp_c = {pend & f.dren, pend & f.dwen, pend & !dhit, !pend, halted, f.regwr & !pend, f.m2r, f.jal, f.luis};
            exp_d = {f.alu, f.rdat2, f.alu, m_load, f.pc4, f.lui, f.wsel};
            n_cmp++;
            if ({dmemREN, dmemWEN, stall_for_data, valid_out, halt_out, RegWr_out, MemtoReg_out, jal_s_out, lui_out} !== exp_c) begin
                n_err++; $display("FAIL rand_ctrl cyc %0d got %b want %b", i, {dmemREN, dmemWEN, stall_for_data, valid_out, halt_out, RegWr_out, MemtoReg_out, jal_s_out, lui_out}, exp_c);
            end
            n_cmp++;
            if ({dmemaddr, dmemstore, aluout_out, load_out, pcplusfour_out, luiout_out, wsel_out} !== exp_d) begin
                n_err++; $display("FAIL rand_data cyc %0d got %h want %h", i, {dmemaddr, dmemstore, aluout_out, load_out, pcplusfour_out, luiout_out, wsel_out}, exp_d);
            end
            // An access finishes on dhit; a halted memory op parks the latch instead of accepting more work.
            done = pend && dhit;
            en = ihit && !(pend && !dhit) && !halted && !(done && f.halt);
            if (done && f.dren) m_load = dmemload;
            if (en) begin
                f = nf;
                pend = nf.dren || nf.dwen;
                halted = !pend && nf.halt;
            end else if (done) begin
                pend = 0;
                halted = f.halt;
            end
            hcnt = halted ? hcnt + 1 : 0;
            tick();
        end
        clear_in();
    endtask

    initial begin
        clear_in();
        test_reset();
        test_alu();
        test_load();
        test_dhit_no_ihit();
        test_store();
        test_halt();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
